ppu_stream: RTL
===============

Name: ppu_stream

Overview:
Parametrised, stream-handshaked post-processing unit between the systolic accumulator output and the vector-scale buffer/quantizer. Per lane it applies a per-row scale, a bias add, a selectable activation, and round/saturate to OUT_W. Coefficients are runtime-loadable and data flows under valid/ready backpressure. A 2-stage pipeline emits each result with its vector address.

Parameters:
LANES, 16, parallel channels per beat
ACC_W, 24, signed accumulator width per lane
COEF_W, 16, signed scale/bias width (fixed point, FRAC fractional bits)
FRAC, 10, fractional bits of coefficients and of the product
OUT_W, 18, signed output width per lane
ROWS, 16, beats per tile; depth of scale/bias tables
TILES, 4, tiles per vector; output address range is ROWS*TILES

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_cfg_we  in  1  coefficient write strobe, honoured only in IDLE
i_cfg_sel  in  1  0 = scale table, 1 = bias table
i_cfg_addr  in  clog2(ROWS)  table row
i_cfg_data  in  LANES*COEF_W  row contents
i_mode  in  2  00 bypass, 01 relu, 10 leaky (optional), 11 reserved (= bypass); latched on start
i_start  in  1  begin one vector; ignored unless IDLE
i_acc_valid  in  1  input beat valid
i_acc_data  in  LANES*ACC_W  accumulator beat
o_acc_ready  out  1  input beat accepted when valid&&ready
o_valid  out  1  output beat valid
i_ready  in  1  downstream ready
o_data  out  LANES*OUT_W  result beat
o_addr  out  clog2(ROWS*TILES)  tile*ROWS+row of this beat
o_last  out  1  final beat of vector
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pulse at vector completion

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, pipeline valids 0. Tables are not reset (contents undefined until written).
- Reset asserted mid-vector: immediate abort, return to IDLE, no o_done.
- States:
  - IDLE: on i_start go to RUN; clear row/tile counters; latch i_mode.
  - RUN: on every accepted beat, row increments; at row = ROWS-1 it wraps to 0 and tile increments. Accepting beat (ROWS-1, TILES-1) moves to DRAIN.
  - DRAIN: stay until both pipeline stages are empty, then go to IDLE and pulse o_done the same cycle.
- Pipeline advance: en = !s2_valid || i_ready. o_acc_ready = (state==RUN) && en. Stage 1 and stage 2 advance only on en. o_data, o_addr and o_last stay stable while o_valid && !i_ready.
- Latency: beat accepted at cycle t produces o_valid at t+2 when no stall.
- Stage 1 (registered): p = signed scale[row] * signed acc, width ACC_W+COEF_W. Then s = p + sign-extended bias[row], width ACC_W+COEF_W+1. Row address, tile address and last flag travel with the data.
- Stage 2 (registered), activation:
  - bypass: s passes through unchanged.
  - relu: negative s becomes 0.
  - Negative values in bypass mode pass through; relu disable never zeroes data.
- Stage 2 rounding: shift right by FRAC, round half away from zero on magnitude (+1 when bit FRAC-1 of |s| is set).
- Stage 2 saturation: symmetric to [-(2^(OUT_W-1)-1), +(2^(OUT_W-1)-1)].
- i_cfg_we outside IDLE is ignored. A cfg write in the same cycle as i_start completes before the first beat is used.

Optional Feature:
PPU_LEAKY_EN:
- Defined: mode 10 applies leaky relu; negative s is arithmetically shifted right by 3 before rounding.
- Undefined: mode 10 behaves as bypass and no leaky logic is generated.

Decomposition:
- Package ppu_pkg holds:
  - mode encodings (MODE_BYPASS, MODE_RELU, MODE_LEAKY)
  - state encodings
  - LEAKY_SHIFT=3
  - a round/saturate function
- Sub-module ppu_lane is one lane's multiply, bias add, activation and round/saturate, generated LANES times. ppu_stream keeps the FSM, counters, tables and handshake.

Test Plan:
1. Reset asserted mid-RUN -> o_valid, o_done, o_acc_ready and o_busy go to 0 at once; next i_start runs a clean vector starting at o_addr 0.
2. Bypass: scale=1024, bias=0, acc=5 and -7 -> out 5 and -7, exactly 2 cycles after acceptance.
3. Rounding:
   - scale=512 (0.5): acc 3 -> 2, acc -3 -> -2, acc 1 -> 1, acc 0 -> 0.
   - bias=-512 with scale 1024: acc 0 -> -1.
4. Saturation/relu:
   - scale=1024, acc=8388607 -> 131071.
   - acc=-8388608 -> -131071 in bypass, 0 in relu.
5. Backpressure: 64 valid beats with i_ready low for 5 cycles mid-stream -> no loss or duplication; o_addr runs 0..63 in order; o_last only on 63; o_done one cycle after the last output handshake.
6. PPU_LEAKY_EN defined, mode 10, s=-80.0 (scale 1024, acc -80) -> -10; without the macro -> -80.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared encodings and the round/saturate helper for the post-processing unit.
// Leaky activation is only built when PPU_LEAKY_EN is defined.
package ppu_pkg;

  typedef logic [1:0] ppu_mode_t;
  typedef logic [1:0] ppu_state_t;

  localparam ppu_mode_t MODE_BYPASS = 2'b00;
  localparam ppu_mode_t MODE_RELU   = 2'b01;
  localparam ppu_mode_t MODE_LEAKY  = 2'b10;

  localparam ppu_state_t ST_IDLE  = 2'd0;
  localparam ppu_state_t ST_RUN   = 2'd1;
  localparam ppu_state_t ST_DRAIN = 2'd2;

  localparam int LEAKY_SHIFT = 3;

  // Drops frac fractional bits rounding half away from zero, then clamps
  // symmetrically so the most negative code of out_w bits is never produced.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                   input int frac,
                                                   input int out_w);
    logic [63:0] mag;
    logic [63:0] q;
    logic [63:0] lim;
    mag = v[63] ? 64'(-v) : 64'(v);
    q   = (mag >> frac) + ((mag >> (frac - 1)) & 64'd1);
    lim = (64'd1 << (out_w - 1)) - 64'd1;
    if (q > lim) q = lim;
    return v[63] ? -$signed(q) : $signed(q);
  endfunction

endpackage

// File: rtl/ppu_lane.sv
// One lane: scale multiply and bias add (stage 1), activation and round/saturate (stage 2).
// Leaky relu for mode 10 exists only when PPU_LEAKY_EN is defined.
module ppu_lane
  import ppu_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int COEF_W = 16,
  parameter int FRAC   = 10,
  parameter int OUT_W  = 18
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [1:0]               i_mode,
  input  logic signed [COEF_W-1:0] i_scale,
  input  logic signed [COEF_W-1:0] i_bias,
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [OUT_W-1:0]  o_data
);

  localparam int PW = ACC_W + COEF_W;
  localparam int SW = PW + 1;

  logic signed [PW-1:0]    prod;
  logic signed [SW-1:0]    sum_d;
  logic signed [SW-1:0]    s1_q;
  logic signed [SW-1:0]    act;
  logic signed [OUT_W-1:0] res_d;
  logic signed [OUT_W-1:0] res_q;

  assign prod  = PW'(i_scale) * PW'(i_acc);
  assign sum_d = SW'(prod) + SW'(i_bias);

  always_comb begin
    act = s1_q;
    case (i_mode)
      MODE_RELU: begin
        if (s1_q[SW-1]) act = '0;
      end
`ifdef PPU_LEAKY_EN
      MODE_LEAKY: begin
        if (s1_q[SW-1]) act = s1_q >>> LEAKY_SHIFT;
      end
`endif
      default: ;
    endcase
  end

  assign res_d = OUT_W'(round_sat(64'(act), FRAC, OUT_W));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q  <= '0;
      res_q <= '0;
    end else if (i_en) begin
      s1_q  <= sum_d;
      res_q <= res_d;
    end
  end

  assign o_data = res_q;

endmodule

// File: rtl/ppu_stream.sv
// Stream post-processing unit: per-row scale/bias tables, vector FSM, 2-stage lane pipeline.
// Define PPU_LEAKY_EN to build leaky relu for mode 10 (otherwise mode 10 is bypass).
module ppu_stream
  import ppu_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int ACC_W  = 24,
  parameter int COEF_W = 16,
  parameter int FRAC   = 10,
  parameter int OUT_W  = 18,
  parameter int ROWS   = 16,
  parameter int TILES  = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_cfg_we,
  input  logic                            i_cfg_sel,
  input  logic [$clog2(ROWS)-1:0]         i_cfg_addr,
  input  logic [LANES*COEF_W-1:0]         i_cfg_data,
  input  logic [1:0]                      i_mode,
  input  logic                            i_start,
  input  logic                            i_acc_valid,
  input  logic [LANES*ACC_W-1:0]          i_acc_data,
  output logic                            o_acc_ready,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [LANES*OUT_W-1:0]          o_data,
  output logic [$clog2(ROWS*TILES)-1:0]   o_addr,
  output logic                            o_last,
  output logic                            o_busy,
  output logic                            o_done
);

  localparam int RW = $clog2(ROWS);
  localparam int AW = $clog2(ROWS * TILES);
  localparam int TW = (TILES > 1) ? $clog2(TILES) : 1;

  logic [LANES*COEF_W-1:0] scale_mem [ROWS];
  logic [LANES*COEF_W-1:0] bias_mem  [ROWS];

  ppu_state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [TW-1:0] tile_q, tile_d;
  ppu_mode_t     mode_q, mode_d;

  logic          s1_valid_q, s2_valid_q;
  logic [AW-1:0] s1_addr_q, s2_addr_q;
  logic          s1_last_q, s2_last_q;

  logic          en;
  logic          accept;
  logic          last_beat;
  logic          pipe_empty;
  logic [AW-1:0] beat_addr;
  logic [LANES*COEF_W-1:0] scale_row;
  logic [LANES*COEF_W-1:0] bias_row;
  logic [LANES*OUT_W-1:0]  lane_out;

  // Coefficients only change between vectors so a beat never sees a half-written row.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_IDLE && i_cfg_we) begin
      if (i_cfg_sel) bias_mem[i_cfg_addr]  <= i_cfg_data;
      else           scale_mem[i_cfg_addr] <= i_cfg_data;
    end
  end

  assign scale_row = scale_mem[row_q];
  assign bias_row  = bias_mem[row_q];

  assign en          = !s2_valid_q || i_ready;
  assign o_acc_ready = (state_q == ST_RUN) && en;
  assign accept      = i_acc_valid && o_acc_ready;
  assign last_beat   = (row_q == RW'(ROWS - 1)) && (tile_q == TW'(TILES - 1));
  assign pipe_empty  = !s1_valid_q && !s2_valid_q;
  assign beat_addr   = AW'(tile_q) * AW'(ROWS) + AW'(row_q);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tile_d  = tile_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          row_d   = '0;
          tile_d  = '0;
          mode_d  = i_mode;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d  = '0;
            tile_d = tile_q + 1'b1;
            if (last_beat) state_d = ST_DRAIN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      tile_q  <= '0;
      mode_q  <= MODE_BYPASS;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      tile_q  <= tile_d;
      mode_q  <= mode_d;
    end
  end

  // Sideband travels alongside the lane registers under the same enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_last_q  <= 1'b0;
    end else if (en) begin
      s1_valid_q <= accept;
      s1_addr_q  <= beat_addr;
      s1_last_q  <= last_beat;
      s2_valid_q <= s1_valid_q;
      s2_addr_q  <= s1_addr_q;
      s2_last_q  <= s1_last_q;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      ppu_lane #(
        .ACC_W  (ACC_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC),
        .OUT_W  (OUT_W)
      ) u_lane (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (en),
        .i_mode  (mode_q),
        .i_scale (scale_row[gi*COEF_W +: COEF_W]),
        .i_bias  (bias_row[gi*COEF_W +: COEF_W]),
        .i_acc   (i_acc_data[gi*ACC_W +: ACC_W]),
        .o_data  (lane_out[gi*OUT_W +: OUT_W])
      );
    end
  endgenerate

  assign o_data  = lane_out;
  assign o_valid = s2_valid_q;
  assign o_addr  = s2_addr_q;
  assign o_last  = s2_last_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = (state_q == ST_DRAIN) && pipe_empty;

endmodule
